// File: rtl/manual_cpu_pkg.sv
// Shared encodings for the manual CPU datapath: ALU ops, writeback select, FSM states.
package manual_cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_LSL = 3'b110,
    ALU_LSR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_IN   = 2'b01,
    WB_MEM  = 2'b10,
    WB_MOVE = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/manual_cpu_alu.sv
// Combinational ALU with Z/N/C/V. Shifter present only when MANUAL_CPU_SHIFT_EN is defined;
// otherwise LSL/LSR pass A through with C=V=0.
module manual_cpu_alu
  import manual_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              v
);

  localparam int MSB = DATA_W - 1;
`ifdef MANUAL_CPU_SHIFT_EN
  localparam int SH_W = $clog2(DATA_W);
`endif

  always_comb begin
    result = a;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        {c, result} = {1'b0, a} + {1'b0, b};
        v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // carry out of A + ~B + 1: 1 means no borrow
        {c, result} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
`ifdef MANUAL_CPU_SHIFT_EN
      // one guard bit catches the last bit shifted out; zero amount leaves it 0
      ALU_LSL: {c, result} = {1'b0, a} << b[SH_W-1:0];
      ALU_LSR: {result, c} = {a, 1'b0} >> b[SH_W-1:0];
`else
      ALU_LSL, ALU_LSR: result = a;
`endif
      default: result = a;
    endcase
  end

  assign z = (result == '0);
  assign n = result[MSB];

endmodule

// File: rtl/manual_cpu_param.sv
// Manual CPU datapath: register file, ALU, data RAM, flags, GO/BUSY/DONE sequencer
// (IDLE->READ->EXEC->WB). Optional shifter via MANUAL_CPU_SHIFT_EN.
module manual_cpu_param
  import manual_cpu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NREG      = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  input  logic [$clog2(NREG)-1:0]  ws,
  input  logic                     we,
  input  logic                     str,
  input  logic                     ldr,
  input  logic [DATA_W-1:0]        in,
  input  logic [2:0]               aluop,
  input  logic [1:0]               dmux,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_W-1:0]        out,
  output logic                     z,
  output logic                     n,
  output logic                     c,
  output logic                     v
);

  localparam int REG_AW = $clog2(NREG);
  localparam int MEM_AW = $clog2(MEM_DEPTH);

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] ws;
    logic              we;
    logic              str;
    logic              ldr;
    logic [DATA_W-1:0] imm;
    alu_op_e           op;
    wb_sel_e           sel;
  } ctrl_t;

  state_e            state;
  ctrl_t             ctl;
  logic [DATA_W-1:0] rf  [NREG];
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] a_q, b_q, res_q, mem_q, wb;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_n, alu_c, alu_v;
  logic [3:0]        flag_q;
  logic              flag_upd;

  manual_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (ctl.op),
    .result (alu_res),
    .z      (alu_z),
    .n      (alu_n),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_comb begin
    wb = res_q;
    if (ctl.ldr) wb = mem_q;
    else begin
      case (ctl.sel)
        WB_ALU:  wb = res_q;
        WB_IN:   wb = ctl.imm;
        WB_MEM:  wb = mem_q;
        WB_MOVE: wb = a_q;
        default: wb = res_q;
      endcase
    end
  end

  // flags only follow ALU writebacks; compares with WE=0 still update them
  assign flag_upd = !ctl.ldr && (ctl.sel == WB_ALU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ctl          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      out          <= '0;
      {z, n, c, v} <= 4'b0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      flag_q       <= 4'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          ctl   <= '{rs1: rs1, rs2: rs2, ws: ws, we: we, str: str, ldr: ldr,
                     imm: in, op: alu_op_e'(aluop), sel: wb_sel_e'(dmux)};
          busy  <= 1'b1;
          state <= S_READ;
        end
        S_READ: begin
          a_q   <= rf[ctl.rs1];
          b_q   <= rf[ctl.rs2];
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q  <= alu_res;
          flag_q <= {alu_z, alu_n, alu_c, alu_v};
          done   <= 1'b1;
          state  <= S_WB;
        end
        S_WB: begin
          if (ctl.we) rf[ctl.ws] <= wb;
          if (flag_upd) {z, n, c, v} <= flag_q;
          out   <= wb;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is not reset; a reset mid-operation leaves state IDLE so no WB store occurs
  always_ff @(posedge clk) begin
    if (state == S_EXEC) mem_q <= mem[a_q[MEM_AW-1:0]];
    if (state == S_WB && ctl.str) mem[a_q[MEM_AW-1:0]] <= b_q;
  end

endmodule
